xor_unfold_rx: RTL and testbench

// - Receive side of the 16-bit XOR-fold link. The transmit side sends, per word,
//   the high half and the folded half (lo ^ hi).
// - This block accepts a byte stream of a_hi, aa, b_hi, bb (plus an optional

---
 rtl/xor_unfold_if.sv | 26 ++
 rtl/xor_unfold_rx.sv | 168 ++++++++++++++++
 tb/tb_xor_unfold_rx.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/xor_unfold_if.sv
// Valid/ready bundle for the XOR-unfold receiver: byte stream in, reconstructed word pair out.
// master = stream source / pair consumer, slave = the receiver block.
interface xor_unfold_if #(
    parameter int HALF_W = 8,
    parameter int CNT_W  = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [HALF_W-1:0]     in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*HALF_W-1:0]   out_a;
    logic [2*HALF_W-1:0]   out_b;
    logic [CNT_W-1:0]      frame_cnt;
    logic                  chk_err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_a, out_b, frame_cnt, chk_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_a, out_b, frame_cnt, chk_err
    );
endinterface

// File: rtl/xor_unfold_rx.sv
// Receive side of the 16-bit XOR-fold link: rebuilds {hi, fold^hi} word pairs from a byte stream.
// Optional check-byte stage enabled by defining XOR_UNFOLD_CHK_EN.
module xor_unfold_rx #(
    parameter int HALF_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst,
    xor_unfold_if.slave  bus
);
    localparam int WORD_W = 2 * HALF_W;

    typedef enum logic [2:0] {
        S_AHI   = 3'd0,
        S_AFOLD = 3'd1,
        S_BHI   = 3'd2,
        S_BFOLD = 3'd3
`ifdef XOR_UNFOLD_CHK_EN
        , S_CHK = 3'd4
`endif
    } state_t;

    function automatic logic [WORD_W-1:0] unfold(input logic [HALF_W-1:0] hi,
                                                 input logic [HALF_W-1:0] fold);
        return {hi, fold ^ hi};
    endfunction

`ifdef XOR_UNFOLD_CHK_EN
    function automatic logic check_bad(input logic [HALF_W-1:0] afold,
                                       input logic [HALF_W-1:0] bfold,
                                       input logic [HALF_W-1:0] chk);
        return chk != (afold ^ bfold);
    endfunction
`endif

    state_t              state_q, state_d;
    logic                final_st;
    logic                in_ready_c;
    logic                beat;
    logic                final_acc;

    logic [HALF_W-1:0]   ahi_q;
    logic [HALF_W-1:0]   afold_q;
    logic [HALF_W-1:0]   bhi_q;
`ifdef XOR_UNFOLD_CHK_EN
    logic [HALF_W-1:0]   bfold_q;
    logic                chk_err_q, chk_err_d;
`endif

    logic                out_valid_q, out_valid_d;
    logic [WORD_W-1:0]   out_a_q, out_a_d;
    logic [WORD_W-1:0]   out_b_q, out_b_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_AHI;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (beat) begin
            case (state_q)
                S_AHI:   state_d = S_AFOLD;
                S_AFOLD: state_d = S_BHI;
                S_BHI:   state_d = S_BFOLD;
`ifdef XOR_UNFOLD_CHK_EN
                S_BFOLD: state_d = S_CHK;
                S_CHK:   state_d = S_AHI;
`else
                S_BFOLD: state_d = S_AHI;
`endif
                default: state_d = S_AHI;
            endcase
        end
    end

    // Only the last beat of a frame waits on the output register; earlier beats land in staging.
    always_comb begin
`ifdef XOR_UNFOLD_CHK_EN
        final_st = (state_q == S_CHK);
`else
        final_st = (state_q == S_BFOLD);
`endif
        in_ready_c = final_st ? (~out_valid_q | bus.out_ready) : 1'b1;
        beat       = bus.in_valid & in_ready_c;
        final_acc  = beat & final_st;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ahi_q   <= '0;
            afold_q <= '0;
            bhi_q   <= '0;
`ifdef XOR_UNFOLD_CHK_EN
            bfold_q <= '0;
`endif
        end else if (beat) begin
            case (state_q)
                S_AHI:   ahi_q   <= bus.in_data;
                S_AFOLD: afold_q <= bus.in_data;
                S_BHI:   bhi_q   <= bus.in_data;
`ifdef XOR_UNFOLD_CHK_EN
                S_BFOLD: bfold_q <= bus.in_data;
`endif
                default: ;
            endcase
        end
    end

    // A new pair may load in the same cycle the consumer takes the old one.
    always_comb begin
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        frame_cnt_d = frame_cnt_q;
`ifdef XOR_UNFOLD_CHK_EN
        chk_err_d   = chk_err_q;
`endif
        if (final_acc) begin
            out_valid_d = 1'b1;
            out_a_d     = unfold(ahi_q, afold_q);
`ifdef XOR_UNFOLD_CHK_EN
            out_b_d     = unfold(bhi_q, bfold_q);
            chk_err_d   = check_bad(afold_q, bfold_q, bus.in_data);
`else
            out_b_d     = unfold(bhi_q, bus.in_data);
`endif
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            frame_cnt_q <= '0;
`ifdef XOR_UNFOLD_CHK_EN
            chk_err_q   <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef XOR_UNFOLD_CHK_EN
            chk_err_q   <= chk_err_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.frame_cnt = frame_cnt_q;
`ifdef XOR_UNFOLD_CHK_EN
    assign bus.chk_err   = chk_err_q;
`else
    assign bus.chk_err   = 1'b0;
`endif
endmodule

// File: tb/tb_xor_unfold_rx.sv
// Scoreboard bench for xor_unfold_rx: driver pushes expected pairs, monitor pops on handshake.
// Built with CNT_W=2 so the frame counter wraps within a short run.
module tb_xor_unfold_rx;
    localparam int HALF_W = 8;
    localparam int CNT_W  = 2;
`ifdef XOR_UNFOLD_CHK_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    typedef struct {
        logic [15:0]      a;
        logic [15:0]      b;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xor_unfold_if #(.HALF_W(HALF_W), .CNT_W(CNT_W)) bus();

    xor_unfold_rx #(.HALF_W(HALF_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sbq[$];
    logic [7:0]  frm[$];
    int          model_cnt = 0;
    int          errors = 0;
    int          checks = 0;
    int          loads_issued = 0;
    int          loads_seen = 0;
    bit          rdy_rand = 1'b0;
    bit          rdy_val = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] frame_beat(input logic [15:0] a, input logic [15:0] b,
                                              input bit bad, input int idx);
        logic [7:0] afold, bfold;
        afold = a[7:0] ^ a[15:8];
        bfold = b[7:0] ^ b[15:8];
        case (idx)
            0:       return a[15:8];
            1:       return afold;
            2:       return b[15:8];
            3:       return bfold;
            default: return (afold ^ bfold) ^ {7'd0, bad};
        endcase
    endfunction

    // Reference: collect beats; a full frame yields hi/lo words by the unfold rule.
    task automatic model_accept(input logic [7:0] d);
        exp_t e;
        frm.push_back(d);
        if (frm.size() == FL) begin
            e.a = {frm[0], frm[1] ^ frm[0]};
            e.b = {frm[2], frm[3] ^ frm[2]};
`ifdef XOR_UNFOLD_CHK_EN
            e.err = (frm[4] != (frm[1] ^ frm[3]));
`else
            e.err = 1'b0;
`endif
            model_cnt = (model_cnt + 1) % (1 << CNT_W);
            e.cnt = CNT_W'(model_cnt);
            sbq.push_back(e);
            frm.delete();
            loads_issued++;
        end
    endtask

    // Call right after a rising edge (+#1); returns at the same phase.
    task automatic send_beat(input logic [7:0] d);
        bit acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (acc) model_accept(d);
        else begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: beat %0h never accepted", d);
        end
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [15:0] b,
                              input bit bad, input bit gaps);
        for (int i = 0; i < FL; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_beat(frame_beat(a, b, bad, i));
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        sbq.delete();
        frm.delete();
        model_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end

    logic [15:0] pa, pb;
    logic        pe;
    bit          pstall = 1'b0;
    exp_t        me;
    always @(negedge clk) begin
        if (rst) begin
            pstall = 1'b0;
        end else begin
            if (loads_issued != loads_seen) begin
                chk("load_latency", 32'(bus.out_valid), 32'd1);
                loads_seen = loads_issued;
            end
            if (pstall) begin
                chk("stall_a", 32'(bus.out_a), 32'(pa));
                chk("stall_b", 32'(bus.out_b), 32'(pb));
                chk("stall_err", 32'(bus.chk_err), 32'(pe));
            end
            pstall = bus.out_valid && !bus.out_ready;
            pa = bus.out_a;
            pb = bus.out_b;
            pe = bus.chk_err;
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pair_unexpected: got a=%h b=%h with no pair expected",
                             bus.out_a, bus.out_b);
                end else begin
                    me = sbq.pop_front();
                    chk("pair_a", 32'(bus.out_a), 32'(me.a));
                    chk("pair_b", 32'(bus.out_b), 32'(me.b));
                    chk("pair_err", 32'(bus.chk_err), 32'(me.err));
                    chk("pair_cnt", 32'(bus.frame_cnt), 32'(me.cnt));
                end
            end
            chk("in_ready", 32'(bus.in_ready),
                32'((frm.size() != FL - 1) || !bus.out_valid || bus.out_ready));
        end
    end

    initial begin
        logic [15:0] ra, rb;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_a", 32'(bus.out_a), 32'd0);
        chk("rst_out_b", 32'(bus.out_b), 32'd0);
        chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        chk("rst_chk_err", 32'(bus.chk_err), 32'd0);
        sync();

        send_frame(16'h12F0, 16'hABCD, 1'b0, 1'b0);
        @(negedge clk);
        chk("basic_valid", 32'(bus.out_valid), 32'd1);
        chk("basic_a", 32'(bus.out_a), 32'h12F0);
        chk("basic_b", 32'(bus.out_b), 32'hABCD);
        chk("basic_cnt", 32'(bus.frame_cnt), 32'd1);
        @(negedge clk);
        chk("basic_one_cycle", 32'(bus.out_valid), 32'd0);
        sync();

        do_reset();
        send_frame(16'h1357, 16'h2468, 1'b0, 1'b0);
        send_frame(16'h9ABC, 16'hDEF0, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_cnt", 32'(bus.frame_cnt), 32'd2);
        chk("b2b_a", 32'(bus.out_a), 32'h9ABC);
        sync();

        rdy_val = 1'b0;
        send_frame(16'h12F0, 16'hABCD, 1'b0, 1'b0);
        for (int i = 0; i < FL - 1; i++) send_beat(frame_beat(16'h3456, 16'h789A, 1'b0, i));
        bus.in_valid = 1'b1;
        bus.in_data  = frame_beat(16'h3456, 16'h789A, 1'b0, FL - 1);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_hold_a", 32'(bus.out_a), 32'h12F0);
        end
        rdy_val = 1'b1;
        sync();
        send_beat(frame_beat(16'h3456, 16'h789A, 1'b0, FL - 1));
        @(negedge clk);
        chk("bp_new_a", 32'(bus.out_a), 32'h3456);
        chk("bp_new_b", 32'(bus.out_b), 32'h789A);
        sync();

        send_beat(8'h12);
        send_beat(8'hE2);
        do_reset();
        @(negedge clk);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_cnt", 32'(bus.frame_cnt), 32'd0);
        sync();
        send_frame(16'h00FF, 16'h0100, 1'b0, 1'b0);
        @(negedge clk);
        chk("mid_rst_a", 32'(bus.out_a), 32'h00FF);
        chk("mid_rst_b", 32'(bus.out_b), 32'h0100);
        chk("mid_rst_cnt1", 32'(bus.frame_cnt), 32'd1);
        sync();

`ifdef XOR_UNFOLD_CHK_EN
        send_frame(16'h12F0, 16'hABCD, 1'b1, 1'b0);
        @(negedge clk);
        chk("chk_bad_err", 32'(bus.chk_err), 32'd1);
        chk("chk_bad_a", 32'(bus.out_a), 32'h12F0);
        sync();
        send_frame(16'h5A5A, 16'hC3C3, 1'b0, 1'b0);
        @(negedge clk);
        chk("chk_good_err", 32'(bus.chk_err), 32'd0);
        sync();
`endif

        for (int k = 0; k < 4 && model_cnt != 3; k++)
            send_frame(16'($urandom), 16'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        chk("wrap_pre", 32'(bus.frame_cnt), 32'd3);
        sync();
        send_frame(16'hFEDC, 16'hBA98, 1'b0, 1'b0);
        @(negedge clk);
        chk("wrap_zero", 32'(bus.frame_cnt), 32'd0);
        sync();

        rdy_rand = 1'b1;
        for (int k = 0; k < 60; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            send_frame(ra, rb, ($urandom_range(0, 3) == 0), 1'b1);
        end
        rdy_rand = 1'b0;
        rdy_val  = 1'b1;
        for (int n = 0; n < 20 && sbq.size() != 0; n++) sync();
        chk("drain_empty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
